uart_rx_axis_packer: RTL and testbench
======================================

// Module: uart_rx_axis_packer
// PURPOSE
//  Downstream stage of uart_rec: turns the rx_data/rx_valid byte pulses into an AXI-Stream master.
//  Buffers bytes in a FIFO and marks packet ends: m_axis_last is set when the line idles or MAX_PKT is reached.
//  Completes the loopback path: AXIS in -> UART TX -> UART RX -> this block -> AXIS out.
// PARAMETERS
//  WIDTH      8         data bits per beat (matches uart_rec DATA_BITS)
//  DEPTH      8         FIFO entries, power of 2, >=2
//  CLK_RATE   50000000  clk frequency, Hz
//  BAUD       115200    line rate; BIT_CYC = CLK_RATE/BAUD (integer divide)
//  IDLE_BITS  20        idle timeout in bit times; T = IDLE_BITS*BIT_CYC cycles
//  MAX_PKT    16        max bytes per packet, >=1; the byte that reaches it is forced last
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         asynchronous, active-high reset
//  rx_data       in   WIDTH     received byte, valid only while rx_valid=1
//  rx_valid      in   1         one-cycle strobe per received byte
//  m_axis_data   out  WIDTH     FIFO head data
//  m_axis_valid  out  1         FIFO not empty
//  m_axis_ready  in   1         downstream accept
//  m_axis_last   out  1         head beat ends a packet
//  fifo_count    out  clog2(DEPTH)+1  entries currently stored
//  overflow      out  1         sticky: an entry was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, state IDLE, counters 0; all outputs 0.
//  Reset mid-operation discards the pending byte and all FIFO contents. No beat appears after release.
//  Hold-back register PEND {data} plus pkt_cnt (bytes in current packet, PEND included) and idle timer.
//  FSM:
//   IDLE: no PEND. On rx_valid, capture the byte into PEND, set pkt_cnt=1 and timer=0.
//         If MAX_PKT==1, push it with last=1 the same cycle and stay in IDLE; otherwise go to HOLD.
//   HOLD: timer increments each cycle without rx_valid.
//    - Expiry when the timer reaches T (byte captured at N, no rx_valid in N+1..N+T).
//      At cycle N+T: push PEND with last=1, pkt_cnt=0, go to IDLE.
//    - rx_valid, no expiry the same cycle: push PEND with last=0, capture the new byte, pkt_cnt++, timer=0.
//      If the new pkt_cnt==MAX_PKT, the new byte is pushed with last=1 on the next cycle and the FSM returns to IDLE.
//    - rx_valid in the same cycle as expiry: push old PEND with last=1.
//      The new byte becomes PEND of a new packet (pkt_cnt=1, timer=0), stay in HOLD.
//  At most one push per clock. Push path is registered: a pushed entry is visible on m_axis the next cycle.
//  FIFO is first-word-fall-through, entries {last,data}, pointers wrap modulo DEPTH.
//   m_axis_valid = (count!=0). Pop when m_axis_valid && m_axis_ready.
//   Output data/last hold stable while valid && !ready (AXIS rule).
//  Push while full:
//   - If a pop occurs the same cycle, the push is accepted and the count is unchanged.
//   - Otherwise the entry is dropped, overflow is set to 1 and stays 1 until reset. A dropped last marker is lost.
//  Pop and push while empty: the new entry is not popped that cycle. Pop while empty cannot occur.
//  rx_valid while in reset is ignored. rx_data is sampled only on rx_valid.
// TESTING (bench params: CLK_RATE=1000, BAUD=100, IDLE_BITS=20 -> T=200; DEPTH=4; MAX_PKT=4 unless noted)
//  1 ready=1, single byte 0xA5 -> exactly one beat 0xA5 last=1, valid rises 201 cycles after rx_valid.
//  2 ready=1, bytes 11,22,33 spaced 100 cycles -> beats 11/l0, 22/l0, 33/l1 in order; no extra beats.
//  3 ready=1, bytes 01..06 spaced 100 -> last=1 on 04 (MAX_PKT) and on 06 (timeout); all others l0.
//  4 MAX_PKT=16, ready=0, bytes 01..07 spaced 100.
//    -> count=4 after byte 05 arrives; 05 and 06 are dropped; overflow=1 from the push of 05.
//    Then ready=1 before the timeout -> beats 01,02,03,04 (l0), then 07 (l1).
//  5 FIFO full (4 entries), ready=1 in the same cycle that a push occurs -> count stays 4, no overflow, order preserved.
//  6 PEND holds 0x55 in HOLD, assert rst for 3 cycles -> all outputs 0 immediately.
//    After release, no beat for >T cycles; a new byte 0x66 then yields a single beat 0x66/l1.

Source files
------------

// File: rtl/uart_rx_axis_packer.sv
// Packs uart_rec byte strobes into an AXI-Stream master: bytes are held back one at a time so the
// packet-ending byte (idle timeout or MAX_PKT reached) can be tagged last before it enters the FIFO.
module uart_rx_axis_packer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int CLK_RATE  = 50000000,
    parameter int BAUD      = 115200,
    parameter int IDLE_BITS = 20,
    parameter int MAX_PKT   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_valid,
    output logic [WIDTH-1:0]         m_axis_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic                     m_axis_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int BIT_CYC = CLK_RATE / BAUD;
    localparam int T_IDLE  = IDLE_BITS * BIT_CYC;
    localparam int TW      = $clog2(T_IDLE + 1);
    localparam int NW      = $clog2(MAX_PKT + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_pend_data;
    logic [NW-1:0]     r_pkt_cnt;
    logic [TW-1:0]     r_timer;
    logic              r_push_vld_p1;
    logic              r_push_last_p1;
    logic [WIDTH-1:0]  r_push_data_p1;

    logic [WIDTH:0]    r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_expire;
    logic [NW-1:0]     w_cnt_inc;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic [WIDTH:0]    w_head;

    // Timer counts idle cycles since the pending byte was captured; reaching T ends the packet.
    assign w_expire  = (r_timer == TW'(T_IDLE - 1));
    assign w_cnt_inc = r_pkt_cnt + NW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pend_data    <= '0;
            r_pkt_cnt      <= '0;
            r_timer        <= '0;
            r_push_vld_p1  <= 1'b0;
            r_push_last_p1 <= 1'b0;
            r_push_data_p1 <= '0;
        end else begin
            r_push_vld_p1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_pend_data <= rx_data;
                        r_pkt_cnt   <= NW'(1);
                        r_timer     <= '0;
                        if (MAX_PKT == 1) begin
                            r_push_vld_p1  <= 1'b1;
                            r_push_last_p1 <= 1'b1;
                            r_push_data_p1 <= rx_data;
                            r_pkt_cnt      <= '0;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_expire) begin
                        r_push_vld_p1  <= 1'b1;
                        r_push_last_p1 <= 1'b1;
                        r_push_data_p1 <= r_pend_data;
                        if (rx_valid) begin
                            r_pend_data <= rx_data;
                            r_pkt_cnt   <= NW'(1);
                            r_timer     <= '0;
                        end else begin
                            r_pkt_cnt <= '0;
                            r_state   <= S_IDLE;
                        end
                    end else if (rx_valid) begin
                        r_push_vld_p1  <= 1'b1;
                        r_push_last_p1 <= 1'b0;
                        r_push_data_p1 <= r_pend_data;
                        r_pend_data    <= rx_data;
                        r_pkt_cnt      <= w_cnt_inc;
                        r_timer        <= '0;
                        if (w_cnt_inc == NW'(MAX_PKT))
                            r_state <= S_FLUSH;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_FLUSH: begin
                    // Pending byte completed a full packet; a byte arriving now starts the next one.
                    r_push_vld_p1  <= 1'b1;
                    r_push_last_p1 <= 1'b1;
                    r_push_data_p1 <= r_pend_data;
                    if (rx_valid) begin
                        r_pend_data <= rx_data;
                        r_pkt_cnt   <= NW'(1);
                        r_timer     <= '0;
                        r_state     <= S_HOLD;
                    end else begin
                        r_pkt_cnt <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO stage: a push into a full FIFO is only accepted when a pop frees a slot the same cycle.
    assign w_pop  = (r_count != '0) && m_axis_ready;
    assign w_full = (r_count == CW'(DEPTH));
    assign w_wr   = r_push_vld_p1 && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {r_push_last_p1, r_push_data_p1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_push_vld_p1 && !w_wr)
                r_overflow <= 1'b1;
        end
    end

    // Head entry is gated by valid so reset and empty both present all-zero outputs.
    assign w_head       = r_mem[r_rd_ptr];
    assign m_axis_valid = (r_count != '0);
    assign m_axis_data  = m_axis_valid ? w_head[WIDTH-1:0] : '0;
    assign m_axis_last  = m_axis_valid ? w_head[WIDTH] : 1'b0;
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_rx_axis_packer.sv
// Bench for uart_rx_axis_packer: directed scenarios plus random traffic, every cycle compared
// against a timestamp-based packetizer model feeding a queue-based FIFO model.
module tb_uart_rx_axis_packer;

    localparam int T     = 200;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rdy = 1'b0;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_last, b_last, a_ovf, b_ovf;
    logic [2:0] a_count, b_count;

    uart_rx_axis_packer #(.WIDTH(8), .DEPTH(DEPTH), .CLK_RATE(1000), .BAUD(100),
                          .IDLE_BITS(20), .MAX_PKT(4)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .m_axis_data(a_data), .m_axis_valid(a_valid), .m_axis_ready(rdy),
        .m_axis_last(a_last), .fifo_count(a_count), .overflow(a_ovf));

    uart_rx_axis_packer #(.WIDTH(8), .DEPTH(DEPTH), .CLK_RATE(1000), .BAUD(100),
                          .IDLE_BITS(20), .MAX_PKT(16)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .m_axis_data(b_data), .m_axis_valid(b_valid), .m_axis_ready(rdy),
        .m_axis_last(b_last), .fifo_count(b_count), .overflow(b_ovf));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit sel = 0;
    bit rnd_rdy = 0;
    logic [8:0] beats[$];
    logic [8:0] exp_q[$];

    // Reference model state: pending byte with its arrival time, FIFO as a queue.
    int         cyc = 0;
    bit         m_pend, m_forced, m_ovf, m_push;
    logic [7:0] m_byte;
    int         m_time, m_cnt;
    logic [8:0] m_push_ent;
    logic [8:0] mq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] dut_outs();
        return sel ? {b_valid, b_last, b_data, b_count, b_ovf}
                   : {a_valid, a_last, a_data, a_count, a_ovf};
    endfunction

    function automatic logic [13:0] model_outs();
        logic v;
        v = (mq.size() != 0);
        return {v, v ? mq[0][8] : 1'b0, v ? mq[0][7:0] : 8'h00, 3'(mq.size()), m_ovf};
    endfunction

    task automatic model_reset();
        m_pend = 0; m_forced = 0; m_ovf = 0; m_push = 0; m_cnt = 0;
        mq.delete();
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit r);
        bit np;
        logic [8:0] ne;
        int mp;
        mp = sel ? 16 : 4;
        // FIFO: entry decided on the previous edge lands now
        if (mq.size() > 0 && r) void'(mq.pop_front());
        if (m_push) begin
            if (mq.size() < DEPTH) mq.push_back(m_push_ent);
            else m_ovf = 1;
        end
        // Packetizer: a byte ends its packet if it filled MAX_PKT or saw T quiet cycles
        np = 0; ne = '0;
        if (m_pend && m_forced) begin
            np = 1; ne = {1'b1, m_byte}; m_pend = 0;
        end else if (m_pend && (cyc - m_time == T)) begin
            np = 1; ne = {1'b1, m_byte}; m_pend = 0;
        end else if (m_pend && v) begin
            np = 1; ne = {1'b0, m_byte};
        end
        if (v) begin
            m_cnt    = m_pend ? m_cnt + 1 : 1;
            m_byte   = d;
            m_time   = cyc;
            m_pend   = 1;
            m_forced = (m_cnt == mp);
            if (mp == 1) begin
                np = 1; ne = {1'b1, d}; m_pend = 0; m_forced = 0;
            end
        end
        m_push = np; m_push_ent = ne;
        cyc++;
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        logic [13:0] o;
        if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        o = dut_outs();
        if (!rst && o[13] && rdy) beats.push_back(o[12:4]);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(v, d, rdy);
        @(negedge clk);
        chk("outs", 32'(dut_outs()), 32'(model_outs()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00);
    endtask

    task automatic send_spaced(input logic [7:0] d);
        step(1, d);
        idle(99);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_async", 32'(dut_outs()), 32'h0);
        model_reset();
        step(1, 8'h77);
        step(0, 8'h00);
        step(0, 8'h00);
        rst = 0;
        beats.delete();
    endtask

    task automatic check_log(input string tag, input logic [8:0] e[$]);
        chk({tag, "_n"}, 32'(beats.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < beats.size(); i++)
            chk(tag, 32'(beats[i]), 32'(e[i]));
        beats.delete();
    endtask

    initial begin
        int k;
        int g;
        model_reset();
        repeat (3) @(negedge clk);
        sel = 0; chk("rst_state_a", 32'(dut_outs()), 32'h0);
        sel = 1; chk("rst_state_b", 32'(dut_outs()), 32'h0);
        sel = 0;
        rst = 0;

        // single byte: timeout closes the packet, latency 201 cycles
        rdy = 1;
        step(1, 8'hA5);
        k = 0;
        while (!a_valid && k < 300) begin step(0, 8'h00); k++; end
        chk("t1_lat", 32'(k), 32'd201);
        idle(300);
        exp_q = '{9'h1A5};
        check_log("t1", exp_q);

        // three bytes in one packet
        send_spaced(8'h11); send_spaced(8'h22); send_spaced(8'h33);
        idle(300);
        exp_q = '{9'h011, 9'h022, 9'h133};
        check_log("t2", exp_q);

        // MAX_PKT split then timeout
        for (int i = 1; i <= 6; i++) send_spaced(8'(i));
        idle(300);
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h005, 9'h106};
        check_log("t3", exp_q);

        // overflow with MAX_PKT=16 and stalled consumer
        sel = 1; rdy = 0;
        do_reset();
        for (int i = 1; i <= 5; i++) send_spaced(8'(i));
        chk("t4_cnt", 32'(b_count), 32'd4);
        chk("t4_ovf0", 32'(b_ovf), 32'd0);
        send_spaced(8'h06);
        chk("t4_ovf1", 32'(b_ovf), 32'd1);
        step(1, 8'h07);
        idle(50);
        rdy = 1;
        idle(300);
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h107};
        check_log("t4", exp_q);

        // push into a full FIFO coinciding with a pop
        sel = 0; rdy = 0;
        do_reset();
        for (int i = 1; i <= 4; i++) send_spaced(8'(i));
        chk("t5_full", 32'(a_count), 32'd4);
        step(1, 8'h05);
        idle(200);
        rdy = 1;
        step(0, 8'h00);
        rdy = 0;
        chk("t5_cnt", 32'(a_count), 32'd4);
        chk("t5_ovf", 32'(a_ovf), 32'd0);
        rdy = 1;
        idle(20);
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h105};
        check_log("t5", exp_q);

        // reset while a byte is pending
        step(1, 8'h55);
        idle(50);
        do_reset();
        idle(250);
        chk("t6_quiet", 32'(beats.size()), 32'd0);
        step(1, 8'h66);
        idle(300);
        exp_q = '{9'h166};
        check_log("t6", exp_q);

        // random traffic on both packet sizes
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            rnd_rdy = 1;
            for (int n = 0; n < 60; n++) begin
                k = $urandom_range(0, 9);
                if (k < 6)      g = $urandom_range(2, 80);
                else if (k < 8) g = $urandom_range(195, 205);
                else            g = $urandom_range(1, 3);
                idle(g - 1);
                step(1, 8'($urandom));
            end
            rnd_rdy = 0; rdy = 1;
            idle(400);
            chk("rnd_drain", 32'(dut_outs() >> 13), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
